// File: rtl/bp_me_mem_cmd_packer.sv
// bp_me_mem_cmd_packer
// Collects one memory command header and, for writes, the data beats that
// follow it. It presents them together as a single packed command: header
// plus one block-wide data field.
// Optional feature macro: BP_ME_MEM_CMD_PACKER_ERR_CHECK_EN enables the sticky
// protocol error flag. Without it, error_o is tied to 0.
module bp_me_mem_cmd_packer #(
    parameter int header_width_p = 128,
    parameter int data_width_p   = 64,
    parameter int block_width_p  = 512,
    parameter int size_lsb_p     = 0,
    parameter int size_width_p   = 3,
    parameter int wr_bit_p       = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,

    input  logic [header_width_p-1:0] header_i,
    input  logic                      header_v_i,
    output logic                      header_ready_and_o,

    input  logic [data_width_p-1:0]   data_i,
    input  logic                      data_v_i,
    output logic                      data_ready_and_o,

    output logic [header_width_p-1:0] cmd_header_o,
    output logic [block_width_p-1:0]  cmd_data_o,
    output logic                      cmd_v_o,
    input  logic                      cmd_yumi_i,

    output logic                      error_o
);

    localparam int beats_lp          = block_width_p / data_width_p;
    localparam int bytes_per_beat_lp = data_width_p / 8;
    // Five bits hold a beat count of up to 16, including the final value.
    localparam int cnt_width_lp      = 5;
    localparam logic [cnt_width_lp-1:0] cnt_one_lp = cnt_width_lp'(1);

    typedef enum logic [1:0] {
        E_IDLE,
        E_DATA,
        E_SEND
    } state_e;

    state_e                    state_r, state_n;
    logic [header_width_p-1:0] header_r;
    logic [block_width_p-1:0]  data_r;
    logic [cnt_width_lp-1:0]   cnt_r;
    logic [cnt_width_lp-1:0]   beats_r;

    logic                      header_accept;
    logic                      beat_accept;
    logic                      last_beat;
    logic [size_width_p-1:0]   header_size;
    logic                      header_wr;

    // Beats needed for a transfer of 2^size bytes. At least one beat is used.
    // The count is saturated at the number of beats in a block.
    function automatic logic [cnt_width_lp-1:0] beat_count(
        input logic [size_width_p-1:0] size
    );
        logic [31:0] bytes;
        logic [31:0] n;
        bytes = 32'd1 << size;
        n     = bytes / 32'(bytes_per_beat_lp);
        if (n == 32'd0) begin
            n = 32'd1;
        end
        if (n > 32'(beats_lp)) begin
            n = 32'(beats_lp);
        end
        return n[cnt_width_lp-1:0];
    endfunction

    assign header_size = header_i[size_lsb_p +: size_width_p];
    assign header_wr   = header_i[wr_bit_p];
    assign last_beat   = ((cnt_r + cnt_one_lp) == beats_r);

    // State register. Reset forces IDLE immediately and discards any pending command.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= E_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state and handshake outputs. All handshake outputs are Moore outputs of the state.
    always_comb begin
        state_n            = state_r;
        header_ready_and_o = 1'b0;
        data_ready_and_o   = 1'b0;
        cmd_v_o            = 1'b0;
        header_accept      = 1'b0;
        beat_accept        = 1'b0;
        unique case (state_r)
            E_IDLE: begin
                header_ready_and_o = 1'b1;
                if (header_v_i) begin
                    header_accept = 1'b1;
                    state_n       = header_wr ? E_DATA : E_SEND;
                end
            end
            E_DATA: begin
                data_ready_and_o = 1'b1;
                if (data_v_i) begin
                    beat_accept = 1'b1;
                    if (last_beat) begin
                        state_n = E_SEND;
                    end
                end
            end
            E_SEND: begin
                cmd_v_o = 1'b1;
                if (cmd_yumi_i) begin
                    state_n = E_IDLE;
                end
            end
            default: begin
                state_n = E_IDLE;
            end
        endcase
    end

    // Header capture, buffer clear on a new header, and beat placement.
    // Each beat lands in the slot given by the running beat counter.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            header_r <= '0;
            data_r   <= '0;
            cnt_r    <= '0;
            beats_r  <= '0;
        end else if (header_accept) begin
            header_r <= header_i;
            data_r   <= '0;
            cnt_r    <= '0;
            beats_r  <= beat_count(header_size);
        end else if (beat_accept) begin
            cnt_r <= cnt_r + cnt_one_lp;
            for (int i = 0; i < beats_lp; i++) begin
                if (cnt_r == cnt_width_lp'(i)) begin
                    data_r[i*data_width_p +: data_width_p] <= data_i;
                end
            end
        end
    end

    assign cmd_header_o = header_r;
    assign cmd_data_o   = data_r;

`ifdef BP_ME_MEM_CMD_PACKER_ERR_CHECK_EN
    logic error_r;
    logic stray_beat;
    logic oversize;

    // A write whose byte count exceeds the block cannot be represented.
    function automatic logic too_big(input logic [size_width_p-1:0] size);
        logic [31:0] bits;
        bits = (32'd1 << size) << 3;
        return (bits > 32'(block_width_p));
    endfunction

    assign stray_beat = data_v_i && (state_r != E_DATA);
    assign oversize   = header_accept && header_wr && too_big(header_size);

    // Sticky error flag. Only reset clears it.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            error_r <= 1'b0;
        end else if (stray_beat || oversize) begin
            error_r <= 1'b1;
        end
    end

    assign error_o = error_r;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_me_mem_cmd_packer.sv
// Self-checking bench for bp_me_mem_cmd_packer.
// It drives a table of per-cycle vectors, followed by hand-written multi-cycle sequences.
module tb_bp_me_mem_cmd_packer;

    localparam int HW = 128;
    localparam int DW = 64;
    localparam int BW = 512;
`ifdef BP_ME_MEM_CMD_PACKER_ERR_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [HW-1:0] header;
    logic          header_v;
    logic          header_ready;
    logic [DW-1:0] data;
    logic          data_v;
    logic          data_ready;
    logic [HW-1:0] cmd_header;
    logic [BW-1:0] cmd_data;
    logic          cmd_v;
    logic          cmd_yumi;
    logic          error;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bp_me_mem_cmd_packer dut (
        .clk_i              (clk),
        .reset_n_i          (reset_n),
        .header_i           (header),
        .header_v_i         (header_v),
        .header_ready_and_o (header_ready),
        .data_i             (data),
        .data_v_i           (data_v),
        .data_ready_and_o   (data_ready),
        .cmd_header_o       (cmd_header),
        .cmd_data_o         (cmd_data),
        .cmd_v_o            (cmd_v),
        .cmd_yumi_i         (cmd_yumi),
        .error_o            (error)
    );

    typedef struct {
        logic          hv;
        logic [HW-1:0] hdr;
        logic          dv;
        logic [DW-1:0] d;
        logic          yumi;
        logic          e_hr;
        logic          e_dr;
        logic          e_v;
        logic [HW-1:0] e_hdr;
        logic [DW-1:0] e_lo;
        logic [DW-1:0] e_hi;
        logic          chk_mid;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic hv, input logic [HW-1:0] hdr,
                                input logic dv, input logic [DW-1:0] d, input logic yumi,
                                input logic e_hr, input logic e_dr, input logic e_v,
                                input logic [HW-1:0] e_hdr, input logic [DW-1:0] e_lo,
                                input logic [DW-1:0] e_hi, input logic chk_mid);
        vec_t v;
        v.hv = hv; v.hdr = hdr; v.dv = dv; v.d = d; v.yumi = yumi;
        v.e_hr = e_hr; v.e_dr = e_dr; v.e_v = e_v; v.e_hdr = e_hdr;
        v.e_lo = e_lo; v.e_hi = e_hi; v.chk_mid = chk_mid;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and let outputs settle.
    task automatic cyc(input logic hv, input logic [HW-1:0] hdr, input logic dv,
                       input logic [DW-1:0] d, input logic yumi);
        @(negedge clk);
        header_v = hv;
        header   = hdr;
        data_v   = dv;
        data     = d;
        cmd_yumi = yumi;
        #1;
    endtask

    task automatic idle_cyc();
        cyc(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        header_v = 1'b0; data_v = 1'b0; cmd_yumi = 1'b0; header = '0; data = '0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [BW-1:0] exp_blk;
        logic [DW-1:0] val;

        reset_n = 1'b0;
        header_v = 1'b0; header = '0; data_v = 1'b0; data = '0; cmd_yumi = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst hdr_ready", BW'(header_ready), BW'(1'b1));
        chk("rst data_ready", BW'(data_ready), BW'(1'b0));
        chk("rst cmd_v", BW'(cmd_v), BW'(1'b0));
        chk("rst cmd_header", BW'(cmd_header), '0);
        chk("rst cmd_data", cmd_data, '0);
        chk("rst error", BW'(error), BW'(1'b0));
        @(negedge clk);
        reset_n = 1'b1;

        // ---------------- table-driven vectors ----------------
        tbl.push_back(mk(0, 'h0,   0, 'h0, 1, 1, 0, 0, 'h0,   'h0, 'h0, 1));
        tbl.push_back(mk(1, 'h006, 0, 'h0, 0, 1, 0, 0, 'h0,   'h0, 'h0, 1));
        tbl.push_back(mk(1, 'h106, 0, 'h0, 0, 0, 0, 1, 'h006, 'h0, 'h0, 1));
        tbl.push_back(mk(0, 'h0,   0, 'h0, 1, 0, 0, 1, 'h006, 'h0, 'h0, 1));
        tbl.push_back(mk(1, 'h106, 0, 'h0, 0, 1, 0, 0, 'h006, 'h0, 'h0, 1));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0, 'h0, 1, DW'(k), 0, 0, 1, 0, 'h106, 'h0, 'h0, (k < 2)));
        tbl.push_back(mk(0, 'h0,   0, 'h0, 0, 0, 1, 0, 'h106, 'h0, 'h0, 0));
        for (int k = 4; k < 8; k++)
            tbl.push_back(mk(0, 'h0, 1, DW'(k), 0, 0, 1, 0, 'h106, 'h0, 'h0, 0));
        tbl.push_back(mk(1, 'h006, 0, 'h0, 0, 0, 0, 1, 'h106, 'h0, 'h7, 0));
        tbl.push_back(mk(0, 'h0,   0, 'h0, 1, 0, 0, 1, 'h106, 'h0, 'h7, 0));
        tbl.push_back(mk(1, 'h102, 0, 'h0, 0, 1, 0, 0, 'h106, 'h0, 'h7, 0));
        tbl.push_back(mk(0, 'h0,   1, 'hDEADBEEF, 0, 0, 1, 0, 'h102, 'h0, 'h0, 1));
        tbl.push_back(mk(0, 'h0,   0, 'h0, 1, 0, 0, 1, 'h102, 'hDEADBEEF, 'h0, 1));
        tbl.push_back(mk(0, 'h0,   0, 'h0, 0, 1, 0, 0, 'h102, 'hDEADBEEF, 'h0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].hv, tbl[i].hdr, tbl[i].dv, tbl[i].d, tbl[i].yumi);
            chk($sformatf("vec%0d hdr_ready", i), BW'(header_ready), BW'(tbl[i].e_hr));
            chk($sformatf("vec%0d data_ready", i), BW'(data_ready), BW'(tbl[i].e_dr));
            chk($sformatf("vec%0d cmd_v", i), BW'(cmd_v), BW'(tbl[i].e_v));
            chk($sformatf("vec%0d cmd_header", i), BW'(cmd_header), BW'(tbl[i].e_hdr));
            chk($sformatf("vec%0d data_lo", i), BW'(cmd_data[DW-1:0]), BW'(tbl[i].e_lo));
            chk($sformatf("vec%0d data_hi", i), BW'(cmd_data[BW-1 -: DW]), BW'(tbl[i].e_hi));
            if (tbl[i].chk_mid)
                chk($sformatf("vec%0d data_mid", i), BW'(cmd_data[BW-DW-1:DW]), '0);
            chk($sformatf("vec%0d error", i), BW'(error), BW'(1'b0));
        end

        // ---------------- full block with stalls, distinct beats ----------------
        exp_blk = '0;
        cyc(1, 'h106, 0, '0, 0);
        for (int k = 0; k < 8; k++) begin
            if (k % 3 == 1) begin
                idle_cyc();
                chk($sformatf("full stall%0d data_ready", k), BW'(data_ready), BW'(1'b1));
                chk($sformatf("full stall%0d data", k), cmd_data, exp_blk);
            end
            val = 64'hC0DE_0000_0000_0000 | DW'(k + 1);
            cyc(0, '0, 1, val, 0);
            chk($sformatf("full beat%0d data_ready", k), BW'(data_ready), BW'(1'b1));
            chk($sformatf("full beat%0d cmd_v", k), BW'(cmd_v), BW'(1'b0));
            chk($sformatf("full beat%0d data", k), cmd_data, exp_blk);
            exp_blk[k*DW +: DW] = val;
        end
        idle_cyc();
        chk("full cmd_v", BW'(cmd_v), BW'(1'b1));
        chk("full data", cmd_data, exp_blk);
        cyc(0, '0, 0, '0, 1);
        idle_cyc();
        chk("full back idle", BW'(header_ready), BW'(1'b1));

        // ---------------- backpressure on a read ----------------
        cyc(1, 128'h1234_0006, 0, '0, 0);
        for (int c = 0; c < 5; c++) begin
            cyc(1, 'h106, 0, '0, 0);
            chk($sformatf("bp%0d cmd_v", c), BW'(cmd_v), BW'(1'b1));
            chk($sformatf("bp%0d hdr_ready", c), BW'(header_ready), BW'(1'b0));
            chk($sformatf("bp%0d data_ready", c), BW'(data_ready), BW'(1'b0));
            chk($sformatf("bp%0d cmd_header", c), BW'(cmd_header), BW'(128'h1234_0006));
            chk($sformatf("bp%0d cmd_data", c), cmd_data, '0);
        end
        cyc(0, '0, 0, '0, 1);
        chk("bp yumi cycle cmd_v", BW'(cmd_v), BW'(1'b1));
        idle_cyc();
        chk("bp after yumi hdr_ready", BW'(header_ready), BW'(1'b1));
        chk("bp after yumi cmd_v", BW'(cmd_v), BW'(1'b0));

        // ---------------- two-beat write (16 bytes) ----------------
        cyc(1, 'h104, 0, '0, 0);
        cyc(0, '0, 1, 64'h55, 0);
        cyc(0, '0, 1, 64'h66, 0);
        chk("size4 beat1 cmd_v", BW'(cmd_v), BW'(1'b0));
        idle_cyc();
        chk("size4 cmd_v", BW'(cmd_v), BW'(1'b1));
        chk("size4 data", cmd_data, BW'(128'h66_0000_0000_0000_0055));
        cyc(0, '0, 0, '0, 1);

        // ---------------- reset in the middle of a write ----------------
        cyc(1, 'h106, 0, '0, 0);
        for (int k = 0; k < 4; k++) cyc(0, '0, 1, DW'(8'hA1 + k), 0);
        @(negedge clk);
        header_v = 1'b0; data_v = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("midrst cmd_v", BW'(cmd_v), BW'(1'b0));
        chk("midrst data_ready", BW'(data_ready), BW'(1'b0));
        chk("midrst hdr_ready", BW'(header_ready), BW'(1'b1));
        chk("midrst data", cmd_data, '0);
        chk("midrst header", BW'(cmd_header), '0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1, 'h006, 0, '0, 0);
        idle_cyc();
        chk("postrst read cmd_v", BW'(cmd_v), BW'(1'b1));
        chk("postrst read data", cmd_data, '0);
        // Reset while a command is pending drops cmd_v at once.
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("sendrst cmd_v", BW'(cmd_v), BW'(1'b0));
        @(negedge clk);
        reset_n = 1'b1;

        // ---------------- oversize write: 128 bytes saturates at 8 beats ----------------
        cyc(1, 'h107, 0, '0, 0);
        idle_cyc();
        chk("oversize error", BW'(error), BW'(ERR_EN));
        for (int k = 0; k < 8; k++) begin
            cyc(0, '0, 1, DW'(k + 16), 0);
            chk($sformatf("oversize beat%0d cmd_v", k), BW'(cmd_v), BW'(1'b0));
        end
        idle_cyc();
        chk("oversize cmd_v", BW'(cmd_v), BW'(1'b1));
        chk("oversize top beat", BW'(cmd_data[BW-1 -: DW]), BW'(23));
        chk("oversize error held", BW'(error), BW'(ERR_EN));
        cyc(0, '0, 0, '0, 1);
        pulse_reset();
        #1;
        chk("error cleared by reset", BW'(error), BW'(1'b0));

        // ---------------- stray beat in IDLE ----------------
        cyc(0, '0, 1, 64'hBAD, 0);
        chk("stray hdr_ready", BW'(header_ready), BW'(1'b1));
        chk("stray data_ready", BW'(data_ready), BW'(1'b0));
        idle_cyc();
        chk("stray error", BW'(error), BW'(ERR_EN));
        chk("stray data ignored", cmd_data, '0);
        for (int c = 0; c < 3; c++) begin
            cyc(0, '0, 0, '0, 1);
            chk($sformatf("stray error held%0d", c), BW'(error), BW'(ERR_EN));
            chk($sformatf("stray yumi ignored%0d", c), BW'(cmd_v), BW'(1'b0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
